// File: rtl/stoch_fixed_gain_mult.sv
// stoch_fixed_gain_mult: scales stochastic stream probability by GAIN, p(y)=min(1,GAIN*p(a)), via a saturating backlog of owed ones.
// Define STOCH_MULT_SAT_FLAG_EN to build the sticky saturation flag; otherwise sat is tied to 0 and clr_sat is ignored.
module stoch_fixed_gain_mult #(
  parameter int COUNTER_SIZE = 8,
  parameter int GAIN = 2,
  parameter int MAX_COUNT = (1 << COUNTER_SIZE) - 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    en,
  input  logic                    a,
  output logic                    y,
  input  logic                    clr_sat,
  output logic                    sat,
  output logic [COUNTER_SIZE-1:0] backlog
);
  // Sum width leaves headroom so backlog + GAIN never wraps before the clamp test.
  localparam int SW = COUNTER_SIZE + $clog2(GAIN + 1) + 1;
  localparam logic [SW-1:0] GAIN_W = SW'(GAIN);
  localparam logic [SW-1:0] MAX_W = SW'(MAX_COUNT);
  logic [COUNTER_SIZE-1:0] r_backlog;
  logic [SW-1:0]           w_c;
  logic [SW-1:0]           w_n;
  logic                    w_y;
  logic                    w_clamp;
  assign w_c = {{(SW-COUNTER_SIZE){1'b0}}, r_backlog} + (a ? GAIN_W : '0);
  assign w_y = nRST & en & (w_c != '0);
  assign w_n = w_c - {{(SW-1){1'b0}}, w_y};
  assign w_clamp = en & (w_n > MAX_W);
  assign y = w_y;
  assign backlog = r_backlog;
  always_ff @(posedge CLK) begin
    if (!nRST) r_backlog <= '0;
    else if (en) r_backlog <= w_clamp ? MAX_W[COUNTER_SIZE-1:0] : w_n[COUNTER_SIZE-1:0];
  end
`ifdef STOCH_MULT_SAT_FLAG_EN
  logic r_sat;
  // A clamp in the same cycle as clr_sat keeps the flag set.
  always_ff @(posedge CLK) begin
    if (!nRST) r_sat <= 1'b0;
    else if (w_clamp) r_sat <= 1'b1;
    else if (clr_sat) r_sat <= 1'b0;
  end
  assign sat = r_sat;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_sat;
  assign sat = 1'b0;
`endif
endmodule
